conv_core_param: RTL and testbench
==================================

CONV_CORE_PARAM -- requirements
Module: conv_core_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of X and Y samples.
REQ-002 Parameter ADDR_WIDTH, default 5, address width of X and Y memories; max sequence length 2^ADDR_WIDTH.
REQ-003 Parameter MEM_LATENCY, default 1, read latency of X and Y memories in cycles, range 1..4.
REQ-004 Derived constant ACC_WIDTH = 2*DATA_WIDTH+ADDR_WIDTH, width of Z samples.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  single-cycle request to begin a convolution.
REQ-008 cfg_size_x  in  ADDR_WIDTH+1  length of X, 0..2^ADDR_WIDTH.
REQ-009 cfg_size_y  in  ADDR_WIDTH+1  length of Y, 0..2^ADDR_WIDTH.
REQ-010 cfg_signed  in  1  1 = two's-complement samples, 0 = unsigned.
REQ-011 memX_addr / dataX  out ADDR_WIDTH / in DATA_WIDTH  X read port.
REQ-012 memY_addr / dataY  out ADDR_WIDTH / in DATA_WIDTH  Y read port.
REQ-013 memZ_addr  out  ADDR_WIDTH+1  Z write address.
REQ-014 dataZ  out  ACC_WIDTH  Z write data.
REQ-015 writeZ  out  1  Z write strobe.
REQ-016 busy  out  1  high from the cycle after start is accepted until DONE is left.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 Compute Z[n] = sum of X[n-k]*Y[k] over 0<=k<size_y and 0<=n-k<size_x, for n = 0..size_x+size_y-2.
REQ-019 FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
REQ-020 IDLE: start=1 latches cfg_size_x, cfg_size_y and cfg_signed, sets n=0, and enters ISSUE; if either size is 0, enters DONE with no writes.
REQ-021 Start is ignored outside IDLE; cfg inputs are ignored outside the latch cycle.
REQ-022 ISSUE: one term per cycle for k = kmin..kmax, where kmin = max(0, n-size_x+1) and kmax = min(n, size_y-1); drive memX_addr = n-k and memY_addr = k; accumulator clears on ISSUE entry.
REQ-023 Operands arriving MEM_LATENCY cycles after issue are tracked by a valid-tag shift register and multiply-accumulated exactly once.
REQ-024 After kmax is issued, go to DRAIN for MEM_LATENCY cycles, then WRITE for 1 cycle.
REQ-025 WRITE: writeZ=1, memZ_addr=n, dataZ=accumulator; then n+1 goes to ISSUE, or the last n goes to DONE.
REQ-026 DONE: done=1 for 1 cycle, then IDLE; busy=0 in IDLE.
REQ-027 Per output, cycle count = (kmax-kmin+1) + MEM_LATENCY + 1.
REQ-028 Signed mode: operands sign-extended, signed product, accumulator sign-extended to ACC_WIDTH. Unsigned mode: zero-extended.
REQ-029 The accumulator never overflows at ACC_WIDTH; no saturation logic.
REQ-030 memX_addr and memY_addr are registered and hold their last value outside ISSUE; writeZ=0 outside WRITE.

Reset
REQ-031 rst=1 at any clock edge forces IDLE; clears n, k, accumulator, valid tags, memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy and done to 0.
REQ-032 A reset during operation abandons the run with no further writeZ and no done pulse; start is ignored in the rst cycle.

Structure
REQ-033 Package conv_pkg holds the FSM state enum, ACC_WIDTH and MEM_LATENCY bounds.
REQ-034 One sub-module, conv_mac, holds the valid-tag pipeline, sign/zero extension and accumulator; the FSM and address generation stay in conv_core_param.

Verification (DATA_WIDTH=8, ADDR_WIDTH=5, MEM_LATENCY=1 unless stated)
REQ-035 X=[1,2,3], Y=[1,1], unsigned, start at cycle 0 -> Z[0..3]=[1,3,5,3] written at addresses 0..3; done high in cycle 15.
REQ-036 X=[0xFF], Y=[0x80]: signed -> Z[0]=0x0080 (=128); unsigned -> Z[0]=0x7F80.
REQ-037 size_x=32, size_y=32, all samples 0xFF unsigned -> Z[31]=32*65025=2080800 with no overflow; 63 writes.
REQ-038 size_x=0, size_y=4 -> done the cycle after start, with no writeZ.
REQ-039 MEM_LATENCY=3, X=[2,1], Y=[3] -> Z=[6,3]; each output takes 5 cycles.
REQ-040 rst asserted mid-ISSUE of n=2 -> next cycle all outputs are 0, with no done; start is ignored during rst, and a new start afterwards runs correctly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 1-D convolution core and its MAC.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } conv_state_e;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 4;
  localparam int DRAIN_CNT_WIDTH = 2;

  function automatic int calc_acc_width(input int data_width, input int addr_width);
    return 2 * data_width + addr_width;
  endfunction

  localparam int ACC_WIDTH = calc_acc_width(8, 5);

endpackage

// File: rtl/conv_mac.sv
// Valid-tag pipeline, operand extension and accumulator for the convolution core.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_W       = 21,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  issue_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] data_x_i,
  input  logic [DATA_WIDTH-1:0] data_y_i,
  output logic [ACC_W-1:0]      acc_o
);

  logic [MEM_LATENCY-1:0] tag_q;
  logic [MEM_LATENCY-1:0] tag_d;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       acc_d;
  logic [ACC_W-1:0]       ext_x_s;
  logic [ACC_W-1:0]       ext_y_s;
  logic [ACC_W-1:0]       prod_s;

  // Extend operands to accumulator width; the truncated product is exact in two's complement.
  always_comb begin
    if (signed_i) begin
      ext_x_s = {{(ACC_W-DATA_WIDTH){data_x_i[DATA_WIDTH-1]}}, data_x_i};
      ext_y_s = {{(ACC_W-DATA_WIDTH){data_y_i[DATA_WIDTH-1]}}, data_y_i};
    end else begin
      ext_x_s = {{(ACC_W-DATA_WIDTH){1'b0}}, data_x_i};
      ext_y_s = {{(ACC_W-DATA_WIDTH){1'b0}}, data_y_i};
    end
    prod_s = ext_x_s * ext_y_s;
  end

  // Shift issue tags so the oldest bit lines up with the returning read data.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = issue_i;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Accumulator next value: clear wins over a pending term.
  always_comb begin
    if (clr_i) begin
      acc_d = '0;
    end else if (tag_q[MEM_LATENCY-1]) begin
      acc_d = acc_q + prod_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Tag and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      acc_q <= '0;
    end else begin
      tag_q <= tag_d;
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_core_param.sv
// Sequential 1-D convolution engine: FSM and address generation, one product term per cycle
// through conv_mac, one Z write per output sample.
module conv_core_param
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int MEM_LATENCY = 1,
  localparam int ACC_W      = calc_acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_size_x,
  input  logic [ADDR_WIDTH:0]   cfg_size_y,
  input  logic                  cfg_signed,
  output logic [ADDR_WIDTH-1:0] memX_addr,
  input  logic [DATA_WIDTH-1:0] dataX,
  output logic [ADDR_WIDTH-1:0] memY_addr,
  input  logic [DATA_WIDTH-1:0] dataY,
  output logic [ADDR_WIDTH:0]   memZ_addr,
  output logic [ACC_W-1:0]      dataZ,
  output logic                  writeZ,
  output logic                  busy,
  output logic                  done
);

  localparam int NW  = ADDR_WIDTH + 1;
  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT = (MEM_LATENCY < MEM_LATENCY_MIN) ? MEM_LATENCY_MIN :
                       (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;
  localparam logic [NW-1:0]              ONE_N      = NW'(1);
  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_ONE  = DRAIN_CNT_WIDTH'(1);
  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LAST = DRAIN_CNT_WIDTH'(LAT - 1);

  conv_state_e                state_q;
  conv_state_e                state_d;
  logic [NW-1:0]              n_q, n_d;
  logic [NW-1:0]              k_q, k_d;
  logic [DRAIN_CNT_WIDTH-1:0] drain_q, drain_d;
  logic [NW-1:0]              sx_q, sx_d;
  logic [NW-1:0]              sy_q, sy_d;
  logic                       sgn_q, sgn_d;
  logic [ADDR_WIDTH-1:0]      memx_q, memx_d;
  logic [ADDR_WIDTH-1:0]      memy_q, memy_d;
  logic [NW-1:0]              memz_q, memz_d;
  logic                       writez_q, writez_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [NW-1:0]              kmax_s;
  logic [NW-1:0]              last_n_s;
  logic                       clr_s;
  logic                       issue_s;
  logic [ACC_W-1:0]           acc_s;

  function automatic logic [NW-1:0] calc_kmin(input logic [NW-1:0] n, input logic [NW-1:0] sx);
    logic [NW-1:0] r;
    if (n >= sx) begin
      r = n - sx + ONE_N;
    end else begin
      r = '0;
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] calc_kmax(input logic [NW-1:0] n, input logic [NW-1:0] sy);
    logic [NW-1:0] r;
    if (n < sy) begin
      r = n;
    end else begin
      r = sy - ONE_N;
    end
    return r;
  endfunction

  // Wraps through 2^NW but the true value always fits, so the result is exact.
  assign last_n_s = sx_q + sy_q - ONE_N - ONE_N;
  assign kmax_s   = calc_kmax(n_q, sy_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      sgn_q    <= 1'b0;
      memx_q   <= '0;
      memy_q   <= '0;
      memz_q   <= '0;
      writez_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      sgn_q    <= sgn_d;
      memx_q   <= memx_d;
      memy_q   <= memy_d;
      memz_q   <= memz_d;
      writez_q <= writez_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((cfg_size_x == '0) || (cfg_size_y == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (k_q == kmax_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_WRITE: begin
        if (n_q == last_n_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values, derived from the current and next state.
  always_comb begin
    n_d     = n_q;
    k_d     = k_q;
    drain_d = drain_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sgn_d   = sgn_q;
    memx_d  = memx_q;
    memy_d  = memy_q;
    memz_d  = memz_q;
    clr_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sx_d  = cfg_size_x;
          sy_d  = cfg_size_y;
          sgn_d = cfg_signed;
          n_d   = '0;
        end else begin
          n_d = n_q;
        end
      end
      S_ISSUE: begin
        if (state_d == S_ISSUE) begin
          k_d = k_q + ONE_N;
        end else begin
          drain_d = '0;
        end
      end
      S_DRAIN: drain_d = drain_q + DRAIN_ONE;
      S_WRITE: begin
        if (state_d == S_ISSUE) begin
          n_d = n_q + ONE_N;
        end else begin
          n_d = n_q;
        end
      end
      default: n_d = n_q;
    endcase
    // Each output starts at its own kmin with a fresh accumulator.
    if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) begin
      k_d   = calc_kmin(n_d, sx_d);
      clr_s = 1'b1;
    end else begin
      clr_s = 1'b0;
    end
    if (state_d == S_ISSUE) begin
      memx_d = ADDR_WIDTH'(n_d - k_d);
      memy_d = ADDR_WIDTH'(k_d);
    end else begin
      memx_d = memx_q;
      memy_d = memy_q;
    end
    if (state_d == S_WRITE) begin
      memz_d = n_q;
    end else begin
      memz_d = memz_q;
    end
    writez_d = (state_d == S_WRITE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    issue_s  = (state_q == S_ISSUE);
  end

  conv_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACC_W       (ACC_W),
    .MEM_LATENCY (LAT)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr_s),
    .issue_i  (issue_s),
    .signed_i (sgn_q),
    .data_x_i (dataX),
    .data_y_i (dataY),
    .acc_o    (acc_s)
  );

  assign memX_addr = memx_q;
  assign memY_addr = memy_q;
  assign memZ_addr = memz_q;
  assign dataZ     = acc_s;
  assign writeZ    = writez_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_core_param.sv
// Self-checking bench for conv_core_param: directed table, hand-written corner sequences and
// randomized runs against a direct-sum convolution model, on latency-1 and latency-3 instances.
module tb_conv_core_param;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int ZW = 2 * DW + AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start1, start3, cfg_sg;
  logic [AW:0]   cfg_sx, cfg_sy;
  logic [AW-1:0] ax1, ay1, ax3, ay3;
  logic [DW-1:0] dx1, dy1;
  logic [AW:0]   az1, az3;
  logic [ZW-1:0] dz1, dz3;
  logic          wz1, wz3, busy1, busy3, done1, done3;

  logic [DW-1:0] mem_x [32];
  logic [DW-1:0] mem_y [32];
  logic [DW-1:0] px3 [3];
  logic [DW-1:0] py3 [3];

  conv_core_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_size_x(cfg_sx), .cfg_size_y(cfg_sy),
    .cfg_signed(cfg_sg), .memX_addr(ax1), .dataX(dx1), .memY_addr(ay1), .dataY(dy1),
    .memZ_addr(az1), .dataZ(dz1), .writeZ(wz1), .busy(busy1), .done(done1));

  conv_core_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_size_x(cfg_sx), .cfg_size_y(cfg_sy),
    .cfg_signed(cfg_sg), .memX_addr(ax3), .dataX(px3[2]), .memY_addr(ay3), .dataY(py3[2]),
    .memZ_addr(az3), .dataZ(dz3), .writeZ(wz3), .busy(busy3), .done(done3));

  // Synchronous-read memories with 1 and 3 cycles of latency.
  always @(posedge clk) begin
    dx1    <= mem_x[ax1];
    dy1    <= mem_y[ay1];
    px3[0] <= mem_x[ax3];
    py3[0] <= mem_y[ay3];
    px3[1] <= px3[0];
    py3[1] <= py3[0];
    px3[2] <= px3[1];
    py3[2] <= py3[1];
  end

  typedef struct {
    logic [AW:0]   addr;
    logic [ZW-1:0] data;
  } wr_t;
  wr_t wq1[$];
  wr_t wq3[$];

  always @(negedge clk) begin
    if (wz1 === 1'b1) wq1.push_back('{az1, dz1});
    if (wz3 === 1'b1) wq3.push_back('{az3, dz3});
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: direct double sum, plus the per-output cycle budget.
  logic [ZW-1:0] exp_z [64];
  int            exp_n;
  int            exp_cyc;

  function automatic longint sval(input logic [DW-1:0] v, input bit sg);
    if (sg) return longint'($signed(v));
    return longint'(v);
  endfunction

  task automatic build_model(input int sx, input int sy, input bit sg, input int lat);
    longint acc;
    int     terms;
    exp_n   = 0;
    exp_cyc = 1;
    if (sx > 0 && sy > 0) begin
      exp_n = sx + sy - 1;
      for (int n = 0; n < exp_n; n++) begin
        acc   = 0;
        terms = 0;
        for (int k = 0; k < sy; k++) begin
          if (n - k >= 0 && n - k < sx) begin
            acc += sval(mem_x[n-k], sg) * sval(mem_y[k], sg);
            terms++;
          end
        end
        exp_z[n] = acc[ZW-1:0];
        exp_cyc += terms + lat + 1;
      end
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 1) ? done1 : done3;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy3;
  endfunction

  // Entered #1 after a rising edge; that cycle is cycle 0 of the run.
  task automatic run(input int sel, input int sx, input int sy, input bit sg,
                     input string name, output int cyc_o);
    int  cyc;
    bit  seen;
    wr_t q[$];
    wq1.delete();
    wq3.delete();
    cfg_sx = 6'(sx);
    cfg_sy = 6'(sy);
    cfg_sg = sg;
    if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    cfg_sx = 6'($urandom_range(0, 63));
    cfg_sy = 6'($urandom_range(0, 63));
    cfg_sg = ~sg;
    cyc = 1;
    check({name, " busy_after_start"}, 64'(get_busy(sel)), 64'd1);
    seen = get_done(sel);
    while (!seen && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      seen = get_done(sel);
    end
    check({name, " done_seen"}, 64'(seen), 64'd1);
    build_model(sx, sy, sg, (sel == 1) ? 1 : 3);
    check({name, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, 64'(get_done(sel)), 64'd0);
    check({name, " busy_idle"}, 64'(get_busy(sel)), 64'd0);
    if (sel == 1) q = wq1; else q = wq3;
    check({name, " write_count"}, 64'(q.size()), 64'(exp_n));
    for (int i = 0; i < q.size() && i < exp_n; i++) begin
      check($sformatf("%s z_addr[%0d]", name, i), 64'(q[i].addr), 64'(i));
      check($sformatf("%s z_data[%0d]", name, i), 64'(q[i].data), 64'(exp_z[i]));
    end
    cyc_o = cyc;
  endtask

  typedef struct {
    string           name;
    int              sx;
    int              sy;
    bit              sg;
    logic [3:0][7:0] x;
    logic [1:0][7:0] y;
    int              nz;
    logic [3:0][ZW-1:0] z;
    int              done_cyc;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cnt;
    bit bad;
    tbl[0] = '{"basic",    3, 2, 1'b0, {8'd0, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1}, 4,
               {21'd3, 21'd5, 21'd3, 21'd1}, 15};
    tbl[1] = '{"sgn_ff80", 1, 1, 1'b1, {8'd0, 8'd0, 8'd0, 8'hFF}, {8'd0, 8'h80}, 1,
               {21'd0, 21'd0, 21'd0, 21'h00080}, 4};
    tbl[2] = '{"uns_ff80", 1, 1, 1'b0, {8'd0, 8'd0, 8'd0, 8'hFF}, {8'd0, 8'h80}, 1,
               {21'd0, 21'd0, 21'd0, 21'h07F80}, 4};
    tbl[3] = '{"sx_zero",  0, 4, 1'b0, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6}, 0,
               {21'd0, 21'd0, 21'd0, 21'd0}, 1};
    tbl[4] = '{"sy_zero",  5, 0, 1'b1, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6}, 0,
               {21'd0, 21'd0, 21'd0, 21'd0}, 1};

    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    cfg_sx = '0; cfg_sy = '0; cfg_sg = 1'b0;
    for (int j = 0; j < 32; j++) begin mem_x[j] = '0; mem_y[j] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset memX_addr", 64'(ax1), 64'd0);
    check("reset memZ_addr", 64'(az1), 64'd0);
    check("reset dataZ",     64'(dz1), 64'd0);
    check("reset writeZ",    64'(wz1), 64'd0);
    check("reset busy",      64'(busy1), 64'd0);
    check("reset done",      64'(done1), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table with spec-given results.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 32; j++) begin mem_x[j] = '0; mem_y[j] = '0; end
      for (int j = 0; j < 4; j++) mem_x[j] = tbl[i].x[j];
      for (int j = 0; j < 2; j++) mem_y[j] = tbl[i].y[j];
      run(1, tbl[i].sx, tbl[i].sy, tbl[i].sg, tbl[i].name, cyc);
      check({tbl[i].name, " tbl_done_cycle"}, 64'(cyc), 64'(tbl[i].done_cyc));
      check({tbl[i].name, " tbl_writes"}, 64'(wq1.size()), 64'(tbl[i].nz));
      for (int j = 0; j < tbl[i].nz && j < wq1.size(); j++)
        check($sformatf("%s tbl_z[%0d]", tbl[i].name, j), 64'(wq1[j].data), 64'(tbl[i].z[j]));
    end

    // Latency 3: two outputs of five cycles each.
    for (int j = 0; j < 32; j++) begin mem_x[j] = '0; mem_y[j] = '0; end
    mem_x[0] = 8'd2; mem_x[1] = 8'd1; mem_y[0] = 8'd3;
    run(3, 2, 1, 1'b0, "lat3", cyc);
    check("lat3 done_cycle_const", 64'(cyc), 64'd11);
    if (wq3.size() == 2) begin
      check("lat3 z0", 64'(wq3[0].data), 64'd6);
      check("lat3 z1", 64'(wq3[1].data), 64'd3);
    end else begin
      check("lat3 nwrites", 64'(wq3.size()), 64'd2);
    end

    // Full-length unsigned run at maximum magnitude.
    for (int j = 0; j < 32; j++) begin mem_x[j] = 8'hFF; mem_y[j] = 8'hFF; end
    run(1, 32, 32, 1'b0, "full", cyc);
    check("full nwrites", 64'(wq1.size()), 64'd63);
    if (wq1.size() > 31) check("full z31", 64'(wq1[31].data), 64'd2080800);

    // Reset in the middle of ISSUE for n=2, with start held during reset.
    for (int j = 0; j < 32; j++) begin mem_x[j] = '0; mem_y[j] = '0; end
    mem_x[0] = 8'd1; mem_x[1] = 8'd2; mem_x[2] = 8'd3; mem_y[0] = 8'd1; mem_y[1] = 8'd1;
    wq1.delete();
    cfg_sx = 6'd3; cfg_sy = 6'd2; cfg_sg = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cnt = 0;
    while (wq1.size() < 2 && cnt < 200) begin @(posedge clk); #1; cnt++; end
    check("rst_pre two_writes", 64'(wq1.size()), 64'd2);
    check("rst_pre issue_addr", 64'(ax1), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst memX_addr", 64'(ax1), 64'd0);
    check("rst memY_addr", 64'(ay1), 64'd0);
    check("rst memZ_addr", 64'(az1), 64'd0);
    check("rst dataZ",     64'(dz1), 64'd0);
    check("rst writeZ",    64'(wz1), 64'd0);
    check("rst busy",      64'(busy1), 64'd0);
    check("rst done",      64'(done1), 64'd0);
    start1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start1 = 1'b0;
    check("rst start_ignored", 64'(busy1), 64'd0);
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0 || busy1 !== 1'b0) bad = 1'b1;
    end
    check("rst no_done_after", 64'(bad), 64'd0);
    check("rst no_more_writes", 64'(wq1.size()), 64'd2);
    run(1, 3, 2, 1'b0, "post_rst", cyc);

    // Randomized runs on both latencies against the model.
    for (int it = 0; it < 14; it++) begin
      int sx, sy;
      bit sg;
      sx = $urandom_range(0, 32);
      sy = $urandom_range(0, 32);
      if (it < 4) begin sx = $urandom_range(1, 4); sy = $urandom_range(1, 4); end
      sg = 1'($urandom_range(0, 1));
      for (int j = 0; j < 32; j++) begin
        mem_x[j] = 8'($urandom_range(0, 255));
        mem_y[j] = 8'($urandom_range(0, 255));
      end
      run((it % 3 == 0) ? 3 : 1, sx, sy, sg, $sformatf("rand%0d", it), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
